// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse position receiver.
// Holds the FSM encodings, byte-0 field positions and the saturating position update.
package ps2_pkg;

    localparam int FRAME_W  = 8;

    localparam int BTN_L    = 0;
    localparam int BTN_M    = 2;
    localparam int SYNC_BIT = 3;
    localparam int XSIGN    = 4;
    localparam int YSIGN    = 5;
    localparam int XOVF     = 6;
    localparam int YOVF     = 7;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        PKT_B0,
        PKT_B1,
        PKT_B2
    } pkt_state_t;

    // pos + delta in 10-bit signed arithmetic, clamped to the 0..255 range.
    function automatic logic [FRAME_W-1:0] clamp_add(input logic [FRAME_W-1:0] pos,
                                                     input logic [FRAME_W:0]   delta);
        logic [FRAME_W+1:0] sum;
        sum = {2'b00, pos} + {delta[FRAME_W], delta};
        if (sum[FRAME_W+1])
            return '0;
        else if (sum[FRAME_W])
            return '1;
        else
            return sum[FRAME_W-1:0];
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: input synchronizers, falling-edge detect,
// 11-bit frame FSM and inactivity timeout.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   RX_IDLE   | waiting for a start bit (sampled 0)
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | sampling the odd-parity bit
//   RX_STOP   | sampling the stop bit; accept or discard byte
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               pkt_busy,
    output logic [FRAME_W-1:0] rx_byte,
    output logic               rx_valid,
    output logic               rx_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic              clk_m, clk_s, clk_p;
    logic              dat_m, dat_s;
    logic              fall;
    logic              active;
    logic              timeout;
    logic [TW-1:0]     tmr;
    logic [2:0]        bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic              par_ok;
    rx_state_t         state, state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_m <= 1'b1;
            clk_s <= 1'b1;
            clk_p <= 1'b1;
            dat_m <= 1'b1;
            dat_s <= 1'b1;
        end else begin
            clk_m <= ps2_clk;
            clk_s <= clk_m;
            clk_p <= clk_s;
            dat_m <= ps2_data;
            dat_s <= dat_m;
        end
    end

    assign fall   = clk_p & ~clk_s;
    assign active = (state != RX_IDLE) | pkt_busy;
    // Down-counter reloaded by every edge; reaching 1 means TIMEOUT_CYCLES quiet cycles.
    assign timeout = active & ~fall & (tmr == TW'(1));

    always_ff @(posedge clock) begin
        if (reset)
            state <= RX_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = RX_IDLE;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!dat_s) state_nxt = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                RX_PARITY: state_nxt = RX_STOP;
                RX_STOP:   state_nxt = RX_IDLE;
                default:   state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmr      <= TW'(TIMEOUT_CYCLES);
            bit_cnt  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= timeout;

            if (fall || !active || timeout)
                tmr <= TW'(TIMEOUT_CYCLES);
            else
                tmr <= tmr - TW'(1);

            if (fall) begin
                case (state)
                    RX_IDLE: bit_cnt <= '0;
                    RX_DATA: begin
                        shreg   <= {dat_s, shreg[FRAME_W-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: par_ok <= ^{dat_s, shreg};
                    RX_STOP: begin
                        if (par_ok && dat_s) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_position.sv
// PS/2 mouse packet decoder: assembles 3-byte movement packets and keeps
// saturating 8-bit absolute X/Y positions plus the button state.
//
//   state  | meaning
//   -------+------------------------------------------------
//   PKT_B0 | expecting flags byte (bit3 must be 1 to sync)
//   PKT_B1 | expecting dx[7:0]
//   PKT_B2 | expecting dy[7:0]; acceptance updates outputs
module ps2_mouse_position
    import ps2_pkg::*;
#(
    parameter int                 TIMEOUT_CYCLES = 100000,
    parameter logic [FRAME_W-1:0] X_INIT         = 8'h80,
    parameter logic [FRAME_W-1:0] Y_INIT         = 8'h80
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    output logic [FRAME_W-1:0] XPosition,
    output logic [FRAME_W-1:0] YPosition,
    output logic [2:0]         buttons,
    output logic               packet_valid,
    output logic               frame_error
);

    logic [FRAME_W-1:0] rx_byte;
    logic               rx_valid;
    logic               rx_err;
    logic [FRAME_W-1:0] byte0, byte1;
    logic [FRAME_W:0]   dx, dy;
    pkt_state_t         pkt_state, pkt_nxt;

    ps2_rx_byte #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .pkt_busy (pkt_state != PKT_B0),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    always_ff @(posedge clock) begin
        if (reset)
            pkt_state <= PKT_B0;
        else
            pkt_state <= pkt_nxt;
    end

    always_comb begin
        pkt_nxt = pkt_state;
        if (rx_err) begin
            pkt_nxt = PKT_B0;
        end else if (rx_valid) begin
            case (pkt_state)
                PKT_B0:  if (rx_byte[SYNC_BIT]) pkt_nxt = PKT_B1;
                PKT_B1:  pkt_nxt = PKT_B2;
                PKT_B2:  pkt_nxt = PKT_B0;
                default: pkt_nxt = PKT_B0;
            endcase
        end
    end

    // dy comes straight from the byte being accepted; overflowed axes contribute nothing.
    assign dx = byte0[XOVF] ? '0 : {byte0[XSIGN], byte1};
    assign dy = byte0[YOVF] ? '0 : {byte0[YSIGN], rx_byte};

    always_ff @(posedge clock) begin
        if (reset) begin
            byte0        <= '0;
            byte1        <= '0;
            XPosition    <= X_INIT;
            YPosition    <= Y_INIT;
            buttons      <= '0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (rx_err) begin
                frame_error <= 1'b1;
            end else if (rx_valid) begin
                case (pkt_state)
                    PKT_B0: begin
                        if (rx_byte[SYNC_BIT])
                            byte0 <= rx_byte;
                        else
                            frame_error <= 1'b1;
                    end
                    PKT_B1: byte1 <= rx_byte;
                    PKT_B2: begin
                        buttons      <= byte0[BTN_M:BTN_L];
                        XPosition    <= clamp_add(XPosition, dx);
                        YPosition    <= clamp_add(YPosition, dy);
                        packet_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_position.sv
// Directed bench for ps2_mouse_position: bit-level PS/2 frames with
// hand-computed positions, pulse counts, latency and timeout behaviour.
module tb_ps2_mouse_position;

    localparam int TO   = 1000;
    localparam int HALF = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] XPosition, YPosition;
    logic [2:0] buttons;
    logic       packet_valid, frame_error;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int pv_cyc = 0, stop_cyc = 0;
    int pv_base, fe_base;

    ps2_mouse_position #(
        .TIMEOUT_CYCLES(TO),
        .X_INIT(8'h80),
        .Y_INIT(8'h80)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .XPosition    (XPosition),
        .YPosition    (YPosition),
        .buttons      (buttons),
        .packet_valid (packet_valid),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (packet_valid) begin
            pv_cnt++;
            pv_cyc = cyc;
        end
        if (frame_error) fe_cnt++;
        if (packet_valid && frame_error) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        pv_base = pv_cnt;
        fe_base = fe_cnt;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0,
                             input logic stop = 1'b1);
        logic [10:0] frame;
        frame = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            ps2_data = frame[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cycles(2 * HALF);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        wait_cycles(10);
    endtask

    initial begin
        // 1: reset state
        mark();
        do_reset();
        check("reset_x", XPosition, 8'h80);
        check("reset_y", YPosition, 8'h80);
        check("reset_btn", buttons, 3'b000);
        check("reset_pv", pv_cnt - pv_base, 0);
        check("reset_fe", fe_cnt - fe_base, 0);

        // 2: basic packet
        mark();
        send_packet(8'h09, 8'h10, 8'h05);
        check("pkt1_x", XPosition, 8'h90);
        check("pkt1_y", YPosition, 8'h85);
        check("pkt1_btn", buttons, 3'b001);
        check("pkt1_pv", pv_cnt - pv_base, 1);
        check("pkt1_fe", fe_cnt - fe_base, 0);
        check("pkt1_latency", pv_cyc - stop_cyc, 4);

        // 3: saturation
        send_packet(8'h08, 8'h7F, 8'h00);
        check("sat1_x", XPosition, 8'hFF);
        check("sat1_y", YPosition, 8'h85);
        send_packet(8'h08, 8'h7F, 8'h00);
        check("sat2_x", XPosition, 8'hFF);
        check("sat2_y", YPosition, 8'h85);
        send_packet(8'h38, 8'h00, 8'h00);
        check("satneg_x", XPosition, 8'h00);
        check("satneg_y", YPosition, 8'h00);
        check("satneg_btn", buttons, 3'b000);

        // 4: X overflow bit suppresses dx only
        do_reset();
        mark();
        send_packet(8'h48, 8'h50, 8'h05);
        check("ovf_x", XPosition, 8'h80);
        check("ovf_y", YPosition, 8'h85);
        check("ovf_pv", pv_cnt - pv_base, 1);

        // 5: bad parity and bad stop bit, then a clean packet
        do_reset();
        mark();
        send_byte(8'h08);
        send_byte(8'h01, 1'b1);
        wait_cycles(10);
        check("par_fe", fe_cnt - fe_base, 1);
        check("par_pv", pv_cnt - pv_base, 0);
        check("par_x", XPosition, 8'h80);
        send_byte(8'h08, 1'b0, 1'b0);
        wait_cycles(10);
        check("stop_fe", fe_cnt - fe_base, 2);
        mark();
        send_packet(8'h08, 8'h01, 8'h01);
        check("post_err_x", XPosition, 8'h81);
        check("post_err_y", YPosition, 8'h81);
        check("post_err_pv", pv_cnt - pv_base, 1);
        check("post_err_fe", fe_cnt - fe_base, 0);

        // 6: resync, timeout, fresh packet
        mark();
        send_byte(8'h00);
        wait_cycles(10);
        check("resync_fe", fe_cnt - fe_base, 1);
        check("resync_x", XPosition, 8'h81);
        send_byte(8'h08);
        wait_cycles(TO + 200);
        check("timeout_fe", fe_cnt - fe_base, 2);
        check("timeout_pv", pv_cnt - pv_base, 0);
        send_packet(8'h08, 8'h02, 8'h00);
        check("fresh_x", XPosition, 8'h83);
        check("fresh_y", YPosition, 8'h81);
        check("fresh_pv", pv_cnt - pv_base, 1);
        check("fresh_fe", fe_cnt - fe_base, 2);

        // negative deltas and all buttons
        send_packet(8'h3F, 8'hFE, 8'hFF);
        check("neg_x", XPosition, 8'h81);
        check("neg_y", YPosition, 8'h80);
        check("neg_btn", buttons, 3'b111);

        check("pv_fe_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
